dsp_mac_sequencer: RTL and testbench

DSP_MAC_SEQUENCER -- requirements
Module: dsp_mac_sequencer

---
 rtl/dsp_seq_pkg.sv | 21 ++
 rtl/dsp_tag_pipe.sv | 54 +++++
 rtl/dsp_mac_sequencer.sv | 141 ++++++++++++++
 tb/tb_dsp_mac_sequencer.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_seq_pkg.sv
// Shared types and widths for the DSP MAC sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, default DSP pipeline latency, operand/accumulator widths.
package dsp_seq_pkg;

  localparam int DSP_LAT_DEF = 4;

  localparam int A_W = 25;
  localparam int D_W = 30;
  localparam int B_W = 18;
  localparam int P_W = 48;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    HOLD
  } state_t;

endpackage

// File: rtl/dsp_tag_pipe.sv
// Delay line carrying per-beat valid/first/last tags alongside the DSP datapath.
// Latency: a tag entering in cycle t leaves the last stage in cycle t+DEPTH.
// Backpressure: none, shifts every cycle.
// Ports: clk/rst; in_vld/in_first/in_last tag input;
//        zero_o = first beat at stage DEPTH-2, done_o = last beat at final stage.
module dsp_tag_pipe #(
  parameter int DEPTH = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic in_vld,
  input  logic in_first,
  input  logic in_last,
  output logic zero_o,
  output logic done_o
);

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [DEPTH-1:0] last_q, last_d;
  // The first flag is only consumed one stage before the end, so it stops there.
  logic [DEPTH-2:0] first_q, first_d;

  always_comb begin
    vld_d    = '0;
    last_d   = '0;
    first_d  = '0;
    vld_d[0]   = in_vld;
    last_d[0]  = in_last;
    first_d[0] = in_first;
    for (int i = 1; i < DEPTH; i++) begin
      vld_d[i]  = vld_q[i-1];
      last_d[i] = last_q[i-1];
    end
    for (int i = 1; i < DEPTH-1; i++) begin
      first_d[i] = first_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= '0;
      last_q  <= '0;
      first_q <= '0;
    end else begin
      vld_q   <= vld_d;
      last_q  <= last_d;
      first_q <= first_d;
    end
  end

  assign zero_o = vld_q[DEPTH-2] & first_q[DEPTH-2];
  assign done_o = vld_q[DEPTH-1] & last_q[DEPTH-1];

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Sequences operand reads into an external DSP and returns the accumulated dot product.
// Latency: job accept in cycle c -> res_valid in cycle c+N+2+DSP_LAT (N = job_len+1).
// Backpressure: result held until res_ready; job_ready low for the whole job incl. HOLD.
// Ports: job_valid/job_ready/job_base/job_len job in; rd_en/rd_addr + rd_a/rd_d/rd_b memory;
//        dsp_a/dsp_d/dsp_b/dsp_pci_zero/dsp_p DSP slice; res_valid/res_ready/res_data result.
module dsp_mac_sequencer
  import dsp_seq_pkg::*;
#(
  parameter int DSP_LAT = DSP_LAT_DEF,
  parameter int ADDR_W  = 10,
  parameter int LEN_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  job_valid,
  output logic                  job_ready,
  input  logic [ADDR_W-1:0]     job_base,
  input  logic [LEN_W-1:0]      job_len,
  output logic                  rd_en,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic signed [A_W-1:0] rd_a,
  input  logic signed [D_W-1:0] rd_d,
  input  logic signed [B_W-1:0] rd_b,
  output logic signed [A_W-1:0] dsp_a,
  output logic signed [D_W-1:0] dsp_d,
  output logic signed [B_W-1:0] dsp_b,
  output logic                  dsp_pci_zero,
  input  logic signed [P_W-1:0] dsp_p,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic signed [P_W-1:0] res_data
);

  state_t                state_q, state_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [LEN_W-1:0]      cnt_q, cnt_d;
  logic                  rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]     rd_addr_q, rd_addr_d;
  logic                  res_valid_q, res_valid_d;
  logic signed [P_W-1:0] res_data_q, res_data_d;

  logic tag_first;
  logic tag_last;
  logic acc_zero;
  logic last_out;

  // Read data lands on the DSP ports the cycle after rd_en, with no extra staging.
  assign dsp_a = rd_a;
  assign dsp_d = rd_d;
  assign dsp_b = rd_b;

  // Gated by rst so the handshake is closed during the reset cycle itself.
  assign job_ready    = (state_q == IDLE) && !rst;
  assign rd_en        = rd_en_q;
  assign rd_addr      = rd_addr_q;
  assign res_valid    = res_valid_q;
  assign res_data     = res_data_q;
  assign dsp_pci_zero = acc_zero;

  assign tag_first = rd_en_q && (cnt_q == '0);
  assign tag_last  = rd_en_q && (cnt_q == len_q);

  // One stage covers the memory read, DSP_LAT stages cover the DSP pipe.
  dsp_tag_pipe #(
    .DEPTH (DSP_LAT + 1)
  ) u_tag_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (rd_en_q),
    .in_first (tag_first),
    .in_last  (tag_last),
    .zero_o   (acc_zero),
    .done_o   (last_out)
  );

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    rd_en_d     = rd_en_q;
    rd_addr_d   = rd_addr_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    unique case (state_q)
      IDLE: begin
        if (job_valid) begin
          len_d     = job_len;
          cnt_d     = '0;
          rd_en_d   = 1'b1;
          rd_addr_d = job_base;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (cnt_q == len_q) begin
          rd_en_d = 1'b0;
          state_d = DRAIN;
        end else begin
          cnt_d     = cnt_q + LEN_W'(1);
          rd_addr_d = rd_addr_q + ADDR_W'(1);
        end
      end
      DRAIN: begin
        // dsp_p holds the complete sum exactly while the last tag sits at the end.
        if (last_out) begin
          res_data_d  = dsp_p;
          res_valid_d = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Self-checking bench for dsp_mac_sequencer with an operand memory and DSP slice model.
// Latency: n/a.
// Backpressure: exercised through res_ready stalls and held job_valid.
module tb_dsp_mac_sequencer;
  import dsp_seq_pkg::*;

  localparam int LAT   = 4;
  localparam int AW    = 10;
  localparam int LW    = 8;
  localparam int MEM_N = 1 << AW;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  job_valid = 1'b0;
  logic                  job_ready;
  logic [AW-1:0]         job_base = '0;
  logic [LW-1:0]         job_len = '0;
  logic                  rd_en;
  logic [AW-1:0]         rd_addr;
  logic signed [A_W-1:0] rd_a = '0;
  logic signed [D_W-1:0] rd_d = '0;
  logic signed [B_W-1:0] rd_b = '0;
  logic signed [A_W-1:0] dsp_a;
  logic signed [D_W-1:0] dsp_d;
  logic signed [B_W-1:0] dsp_b;
  logic                  dsp_pci_zero;
  logic signed [P_W-1:0] dsp_p = '0;
  logic                  res_valid;
  logic                  res_ready = 1'b0;
  logic signed [P_W-1:0] res_data;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic signed [A_W-1:0] mem_a [MEM_N];
  logic signed [D_W-1:0] mem_d [MEM_N];
  logic signed [B_W-1:0] mem_b [MEM_N];

  logic [AW-1:0] rd_addr_log [$];
  int            rd_cyc_log  [$];

  dsp_mac_sequencer #(
    .DSP_LAT (LAT),
    .ADDR_W  (AW),
    .LEN_W   (LW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .job_valid    (job_valid),
    .job_ready    (job_ready),
    .job_base     (job_base),
    .job_len      (job_len),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_a         (rd_a),
    .rd_d         (rd_d),
    .rd_b         (rd_b),
    .dsp_a        (dsp_a),
    .dsp_d        (dsp_d),
    .dsp_b        (dsp_b),
    .dsp_pci_zero (dsp_pci_zero),
    .dsp_p        (dsp_p),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Operand memory: one-cycle read; junk on the bus when idle so misalignment shows up.
  always @(posedge clk) begin
    if (rd_en) begin
      rd_a <= mem_a[rd_addr];
      rd_d <= mem_d[rd_addr];
      rd_b <= mem_b[rd_addr];
    end else begin
      rd_a <= A_W'($urandom);
      rd_d <= D_W'($urandom);
      rd_b <= B_W'($urandom);
    end
  end

  // DSP slice: ports to dsp_p in LAT cycles, accumulate at the final register.
  logic signed [A_W-1:0] dsp_diff;
  logic signed [P_W-1:0] dsp_prod;
  logic signed [P_W-1:0] prod_pipe [LAT-1] = '{default: '0};
  assign dsp_diff = A_W'(dsp_a - dsp_d);
  assign dsp_prod = dsp_diff * dsp_b;

  always @(posedge clk) begin
    dsp_p <= (dsp_pci_zero ? '0 : dsp_p) + prod_pipe[LAT-2];
    for (int i = LAT-2; i > 0; i--) prod_pipe[i] <= prod_pipe[i-1];
    prod_pipe[0] <= dsp_prod;
  end

  always @(negedge clk) begin
    if (rd_en === 1'b1) begin
      rd_addr_log.push_back(rd_addr);
      rd_cyc_log.push_back(cyc);
    end
  end

  // Reference: plain dot product over the job's address range, modulo 2^48.
  function automatic logic signed [P_W-1:0] ref_mac(input int base, input int n);
    logic signed [P_W-1:0] acc;
    logic signed [A_W-1:0] t;
    logic signed [P_W-1:0] p;
    int ad;
    acc = '0;
    for (int k = 0; k < n; k++) begin
      ad  = (base + k) % MEM_N;
      t   = A_W'(mem_a[ad] - mem_d[ad]);
      p   = t * mem_b[ad];
      acc = acc + p;
    end
    return acc;
  endfunction

  // Mismatches between logged reads and the expected address/cycle sequence.
  function automatic int read_errs(input int base, input int n, input int acc);
    int e;
    logic [AW-1:0] ea;
    e = 0;
    if (rd_addr_log.size() != n) return n + 1000;
    for (int k = 0; k < n; k++) begin
      ea = AW'(base + k);
      if (rd_addr_log[k] !== ea || rd_cyc_log[k] != acc + 1 + k) e++;
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int base, input int len, output int acc_c);
    rd_addr_log.delete();
    rd_cyc_log.delete();
    job_base  = AW'(base);
    job_len   = LW'(len);
    job_valid = 1'b1;
    acc_c     = -1;
    for (int i = 0; i < 400 && acc_c < 0; i++) begin
      if (job_ready === 1'b1) acc_c = cyc;
      tick();
    end
    job_valid = 1'b0;
    job_base  = AW'($urandom);
    job_len   = LW'($urandom);
  endtask

  task automatic wait_valid(output int vc);
    vc = -1;
    for (int i = 0; i < 600 && vc < 0; i++) begin
      if (res_valid === 1'b1) vc = cyc;
      else tick();
    end
  endtask

  task automatic release_res();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; job_valid = 1'b1; res_ready = 1'b1;
    repeat (3) tick();
    n_checks++; if (job_ready !== 1'b0) $display("FAIL reset_job_ready: got %b want 0", job_ready); else n_pass++;
    n_checks++; if (res_valid !== 1'b0) $display("FAIL reset_res_valid: got %b want 0", res_valid); else n_pass++;
    n_checks++; if (res_data !== '0) $display("FAIL reset_res_data: got %0d want 0", res_data); else n_pass++;
    n_checks++; if (rd_en !== 1'b0) $display("FAIL reset_rd_en: got %b want 0", rd_en); else n_pass++;
    n_checks++; if (rd_addr !== '0) $display("FAIL reset_rd_addr: got %0d want 0", rd_addr); else n_pass++;
    n_checks++; if (dsp_pci_zero !== 1'b0) $display("FAIL reset_pci_zero: got %b want 0", dsp_pci_zero); else n_pass++;
    job_valid = 1'b0; res_ready = 1'b0; rst = 1'b0;
    #1;
    n_checks++; if (job_ready !== 1'b1) $display("FAIL reset_release_job_ready: got %b want 1", job_ready); else n_pass++;
    tick();
  endtask

  task automatic test_single();
    int base, acc, vc;
    logic signed [P_W-1:0] exp;
    base = $urandom_range(0, MEM_N-1);
    mem_a[base] = 5; mem_d[base] = 2; mem_b[base] = 3;
    exp = 9;
    start_job(base, 0, acc);
    wait_valid(vc);
    n_checks++; if (vc !== acc + 7) $display("FAIL single_latency: got cycle %0d want %0d", vc, acc + 7); else n_pass++;
    n_checks++; if (res_data !== exp) $display("FAIL single_data: got %0d want %0d", res_data, exp); else n_pass++;
    n_checks++; if (read_errs(base, 1, acc) !== 0) $display("FAIL single_reads: got %0d bad want 0", read_errs(base, 1, acc)); else n_pass++;
    release_res();
    n_checks++; if (res_valid !== 1'b0) $display("FAIL single_release: got %b want 0", res_valid); else n_pass++;
  endtask

  task automatic test_four();
    int base, acc, vc, ad;
    int va [4] = '{3, 0, 7, -2};
    int vd [4] = '{1, 4, 7, 0};
    int vb [4] = '{2, 5, 9, -3};
    logic signed [P_W-1:0] exp;
    base = $urandom_range(0, MEM_N-1);
    for (int k = 0; k < 4; k++) begin
      ad = (base + k) % MEM_N;
      mem_a[ad] = A_W'(va[k]); mem_d[ad] = D_W'(vd[k]); mem_b[ad] = B_W'(vb[k]);
    end
    exp = -10;
    start_job(base, 3, acc);
    wait_valid(vc);
    n_checks++; if (vc !== acc + 4 + 2 + LAT) $display("FAIL four_latency: got cycle %0d want %0d", vc, acc + 6 + LAT); else n_pass++;
    n_checks++; if (res_data !== exp) $display("FAIL four_data: got %0d want %0d", res_data, exp); else n_pass++;
    release_res();
  endtask

  task automatic test_random();
    int base, len, acc, vc, ad;
    logic signed [P_W-1:0] exp;
    for (int it = 0; it < 6; it++) begin
      base = $urandom_range(0, MEM_N-1);
      len  = (it == 0) ? 255 : $urandom_range(0, 40);
      if (it == 0) begin
        // Largest-magnitude products over a full-length job force 48-bit wrap.
        for (int k = 0; k < 256; k++) begin
          ad = (base + k) % MEM_N;
          mem_a[ad] = A_W'(-(1 << 24)); mem_d[ad] = '0; mem_b[ad] = B_W'(-(1 << 17) + 1);
        end
      end
      exp = ref_mac(base, len + 1);
      start_job(base, len, acc);
      wait_valid(vc);
      n_checks++; if (vc !== acc + len + 3 + LAT) $display("FAIL random%0d_latency: got %0d want %0d", it, vc, acc + len + 3 + LAT); else n_pass++;
      n_checks++; if (res_data !== exp) $display("FAIL random%0d_data: got %0d want %0d", it, res_data, exp); else n_pass++;
      n_checks++; if (read_errs(base, len + 1, acc) !== 0) $display("FAIL random%0d_reads: got %0d bad want 0", it, read_errs(base, len + 1, acc)); else n_pass++;
      repeat ($urandom_range(0, 3)) tick();
      release_res();
    end
  endtask

  task automatic test_back_to_back();
    int b1, l1, b2, l2, acc1, acc2, rel, busy_rdy, vc1, vc2;
    logic signed [P_W-1:0] e1, e2;
    b1 = $urandom_range(0, MEM_N-1); l1 = $urandom_range(0, 15);
    b2 = $urandom_range(0, MEM_N-1); l2 = $urandom_range(0, 15);
    e1 = ref_mac(b1, l1 + 1);
    e2 = ref_mac(b2, l2 + 1);
    start_job(b1, l1, acc1);
    job_base = AW'(b2); job_len = LW'(l2); job_valid = 1'b1;
    busy_rdy = 0; vc1 = -1;
    for (int i = 0; i < 200 && vc1 < 0; i++) begin
      if (job_ready !== 1'b0) busy_rdy++;
      if (res_valid === 1'b1) vc1 = cyc;
      else tick();
    end
    n_checks++; if (busy_rdy !== 0) $display("FAIL b2b_busy_ready: got %0d cycles want 0", busy_rdy); else n_pass++;
    n_checks++; if (res_data !== e1) $display("FAIL b2b_first_data: got %0d want %0d", res_data, e1); else n_pass++;
    n_checks++; if (read_errs(b1, l1 + 1, acc1) !== 0) $display("FAIL b2b_first_reads: got %0d bad want 0", read_errs(b1, l1 + 1, acc1)); else n_pass++;
    rel = cyc;
    res_ready = 1'b1;
    rd_addr_log.delete(); rd_cyc_log.delete();
    tick();
    res_ready = 1'b0;
    acc2 = -1;
    for (int i = 0; i < 20 && acc2 < 0; i++) begin
      if (job_ready === 1'b1) acc2 = cyc;
      tick();
    end
    job_valid = 1'b0;
    n_checks++; if (acc2 !== rel + 1) $display("FAIL b2b_second_accept: got cycle %0d want %0d", acc2, rel + 1); else n_pass++;
    n_checks++; if (acc2 - acc1 < l1 + 4 + LAT) $display("FAIL b2b_spacing: got %0d want >= %0d", acc2 - acc1, l1 + 4 + LAT); else n_pass++;
    wait_valid(vc2);
    n_checks++; if (vc2 !== acc2 + l2 + 3 + LAT) $display("FAIL b2b_second_latency: got %0d want %0d", vc2, acc2 + l2 + 3 + LAT); else n_pass++;
    n_checks++; if (res_data !== e2) $display("FAIL b2b_second_data: got %0d want %0d", res_data, e2); else n_pass++;
    n_checks++; if (read_errs(b2, l2 + 1, acc2) !== 0) $display("FAIL b2b_second_reads: got %0d bad want 0", read_errs(b2, l2 + 1, acc2)); else n_pass++;
    release_res();
  endtask

  task automatic test_stall();
    int base, len, acc, vc, idle_bad;
    logic signed [P_W-1:0] exp;
    base = $urandom_range(0, MEM_N-1);
    len  = $urandom_range(0, 10);
    exp  = ref_mac(base, len + 1);
    res_ready = 1'b1;
    idle_bad = 0;
    repeat (3) begin
      if (res_valid !== 1'b0 || job_ready !== 1'b1) idle_bad++;
      tick();
    end
    n_checks++; if (idle_bad !== 0) $display("FAIL stall_idle_res_ready: got %0d bad cycles want 0", idle_bad); else n_pass++;
    start_job(base, len, acc);
    res_ready = 1'b0;
    wait_valid(vc);
    n_checks++; if (vc !== acc + len + 3 + LAT) $display("FAIL stall_latency: got %0d want %0d", vc, acc + len + 3 + LAT); else n_pass++;
    for (int i = 0; i < 10; i++) begin
      n_checks++; if (res_valid !== 1'b1) $display("FAIL stall%0d_valid: got %b want 1", i, res_valid); else n_pass++;
      n_checks++; if (res_data !== exp) $display("FAIL stall%0d_data: got %0d want %0d", i, res_data, exp); else n_pass++;
      n_checks++; if (job_ready !== 1'b0) $display("FAIL stall%0d_job_ready: got %b want 0", i, job_ready); else n_pass++;
      tick();
    end
    release_res();
    n_checks++; if (res_valid !== 1'b0) $display("FAIL stall_release_valid: got %b want 0", res_valid); else n_pass++;
    n_checks++; if (job_ready !== 1'b1) $display("FAIL stall_release_ready: got %b want 1", job_ready); else n_pass++;
  endtask

  task automatic test_reset_abort();
    int base, base2, acc, acc2, vc, seen;
    logic [AW-1:0] ea;
    logic signed [P_W-1:0] exp;
    base = $urandom_range(0, MEM_N-1);
    start_job(base, 7, acc);
    tick(); tick();
    ea = AW'(base + 2);
    n_checks++; if (rd_addr !== ea) $display("FAIL abort_beat2_addr: got %0d want %0d", rd_addr, ea); else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++; if (job_ready !== 1'b0) $display("FAIL abort_rst_job_ready: got %b want 0", job_ready); else n_pass++;
    tick();
    rst = 1'b0;
    #1;
    n_checks++; if (rd_en !== 1'b0) $display("FAIL abort_rd_en: got %b want 0", rd_en); else n_pass++;
    n_checks++; if (job_ready !== 1'b1) $display("FAIL abort_job_ready: got %b want 1", job_ready); else n_pass++;
    seen = 0;
    repeat (40) begin
      if (res_valid !== 1'b0) seen++;
      tick();
    end
    n_checks++; if (seen !== 0) $display("FAIL abort_no_result: got %0d valid cycles want 0", seen); else n_pass++;
    base2 = $urandom_range(0, MEM_N-1);
    mem_a[base2] = 1; mem_d[base2] = 0; mem_b[base2] = 1;
    exp = 1;
    start_job(base2, 0, acc2);
    wait_valid(vc);
    n_checks++; if (res_data !== exp) $display("FAIL abort_next_data: got %0d want %0d", res_data, exp); else n_pass++;
    release_res();
  endtask

  task automatic test_wrap();
    int acc, vc;
    int exp_addr [4] = '{1022, 1023, 0, 1};
    logic [AW-1:0] ea;
    logic signed [P_W-1:0] exp;
    exp = ref_mac(MEM_N - 2, 4);
    start_job(MEM_N - 2, 3, acc);
    wait_valid(vc);
    n_checks++; if (rd_addr_log.size() !== 4) $display("FAIL wrap_read_count: got %0d want 4", rd_addr_log.size()); else n_pass++;
    for (int k = 0; k < 4 && k < rd_addr_log.size(); k++) begin
      ea = AW'(exp_addr[k]);
      n_checks++; if (rd_addr_log[k] !== ea) $display("FAIL wrap_addr%0d: got %0d want %0d", k, rd_addr_log[k], ea); else n_pass++;
    end
    n_checks++; if (res_data !== exp) $display("FAIL wrap_data: got %0d want %0d", res_data, exp); else n_pass++;
    release_res();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before end of tests");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < MEM_N; i++) begin
      mem_a[i] = A_W'($urandom);
      mem_d[i] = D_W'($urandom);
      mem_b[i] = B_W'($urandom);
    end
    test_reset();
    test_single();
    test_four();
    test_random();
    test_back_to_back();
    test_stall();
    test_reset_abort();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
